// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared entry states and ALU opcode constants for nanocalc
package calc_pkg;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_ISSUE = 2'd3
    } entry_state_t;

    // Opcode map shared with the ALU core
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;

endpackage

// File: rtl/calc_debounce.sv
// rtl/calc_debounce.sv - button synchroniser, level debouncer and press-pulse generator
module calc_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   r_press;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_press  = r_press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= '0;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_press <= 1'b0;
            if (w_synced == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // New level has held long enough; a rising acceptance is a press
                r_cnt    <= '0;
                r_stable <= w_synced;
                r_press  <= w_synced;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_entry_sequencer.sv
// rtl/calc_entry_sequencer.sv - A/B/opcode entry FSM issuing one ALU command; CALC_TIMEOUT_EN adds idle abort
module calc_entry_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter int OP_W            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw_in,
    input  logic              btn_enter,
    input  logic              btn_clr,
    output logic [DATA_W-1:0] cmd_a,
    output logic [DATA_W-1:0] cmd_b,
    output logic [OP_W-1:0]   cmd_op,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        entry_st,
    output logic              timeout
);

    logic w_enter_p;
    logic w_clr_p;

    calc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk(clk), .rst(rst), .i_btn(btn_enter), .o_press(w_enter_p)
    );

    calc_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .rst(rst), .i_btn(btn_clr), .o_press(w_clr_p)
    );

    entry_state_t      r_state;
    logic [DATA_W-1:0] r_cmd_a;
    logic [DATA_W-1:0] r_cmd_b;
    logic [OP_W-1:0]   r_cmd_op;
    logic              r_cmd_valid;
    logic              r_timeout;

`ifdef CALC_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);
    logic [IW-1:0] r_idle;
    logic          w_idle_hit;
    assign w_idle_hit = (r_idle == IDLE_MAX);
`else
    logic          w_idle_hit;
    assign w_idle_hit = 1'b0;
`endif

    assign cmd_a     = r_cmd_a;
    assign cmd_b     = r_cmd_b;
    assign cmd_op    = r_cmd_op;
    assign cmd_valid = r_cmd_valid;
    assign entry_st  = r_state;
    assign timeout   = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_A;
            r_cmd_a     <= '0;
            r_cmd_b     <= '0;
            r_cmd_op    <= '0;
            r_cmd_valid <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            r_idle      <= '0;
`endif
        end else begin
            r_timeout <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            // Any press or state change restarts the idle window
            if ((r_state == S_B || r_state == S_OP) && !w_enter_p && !w_clr_p && !w_idle_hit)
                r_idle <= r_idle + 1'b1;
            else
                r_idle <= '0;
`endif
            case (r_state)
                S_A: begin
                    if (!w_clr_p && w_enter_p) begin
                        r_cmd_a <= sw_in;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_clr_p) begin
                        r_state <= S_A;
                    end else if (w_enter_p) begin
                        r_cmd_b <= sw_in;
                        r_state <= S_OP;
                    end else if (w_idle_hit) begin
                        r_state   <= S_A;
                        r_timeout <= 1'b1;
                    end
                end
                S_OP: begin
                    if (w_clr_p) begin
                        r_state <= S_A;
                    end else if (w_enter_p) begin
                        r_cmd_op    <= sw_in[OP_W-1:0];
                        r_cmd_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else if (w_idle_hit) begin
                        r_state   <= S_A;
                        r_timeout <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (r_cmd_valid && cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_A;
                    end
                end
                default: r_state <= S_A;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// tb/tb_calc_entry_sequencer.sv - scoreboard bench for calc_entry_sequencer
module tb_calc_entry_sequencer;

    localparam int DW = 8;
    localparam int OW = 4;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int TO = 64;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [OW-1:0] op;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] sw_in;
    logic          btn_enter;
    logic          btn_clr;
    logic [DW-1:0] cmd_a;
    logic [DW-1:0] cmd_b;
    logic [OW-1:0] cmd_op;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    entry_st;
    logic          timeout;

    cmd_t exp_q[$];
    cmd_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   hs_count    = 0;
    int   valid_hi    = 0;
    int   to_count    = 0;

    calc_entry_sequencer #(
        .DATA_W(DW), .OP_W(OW), .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .btn_enter(btn_enter), .btn_clr(btn_clr),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .entry_st(entry_st), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) valid_hi++;
            if (timeout) to_count++;
            if (cmd_valid && cmd_ready) begin
                hs_count++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL handshake_unexpected got a=%h b=%h op=%h, no command expected", cmd_a, cmd_b, cmd_op);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({cmd_a, cmd_b, cmd_op} !== mon_e) begin
                        miscompares++;
                        $display("FAIL handshake_payload got a=%h b=%h op=%h want a=%h b=%h op=%h",
                                 cmd_a, cmd_b, cmd_op, mon_e.a, mon_e.b, mon_e.op);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [DW-1:0] sw, input logic en, input logic cl);
        sw_in     = sw;
        btn_enter = en;
        btn_clr   = cl;
        cyc(10);
        btn_enter = 1'b0;
        btn_clr   = 1'b0;
        cyc(10);
    endtask

    task automatic wait_handshake(input string name);
        int start;
        start = hs_count;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (hs_count != start) break;
        end
        vectors++;
        if (hs_count == start) begin
            miscompares++;
            $display("FAIL %s_timeout got no handshake within 30 cycles want one", name);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; sw_in = '0; btn_enter = 1'b0; btn_clr = 1'b0; cmd_ready = 1'b0;
        cyc(3);
        vectors++;
        if ({cmd_a, cmd_b, cmd_op, cmd_valid, entry_st, timeout} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got a=%h b=%h op=%h v=%b st=%0d to=%b want all 0",
                     cmd_a, cmd_b, cmd_op, cmd_valid, entry_st, timeout);
        end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_enter_sequence;
        int v0;
        cmd_ready = 1'b1;
        press(8'h23, 1'b1, 1'b0);
        vectors++;
        if (entry_st !== 2'd1 || cmd_a !== 8'h23) begin
            miscompares++;
            $display("FAIL seq_a got st=%0d a=%h want st=1 a=23", entry_st, cmd_a);
        end
        press(8'h11, 1'b1, 1'b0);
        vectors++;
        if (entry_st !== 2'd2 || cmd_b !== 8'h11) begin
            miscompares++;
            $display("FAIL seq_b got st=%0d b=%h want st=2 b=11", entry_st, cmd_b);
        end
        v0 = valid_hi;
        exp_q.push_back('{a: 8'h23, b: 8'h11, op: 4'h1});
        press(8'h01, 1'b1, 1'b0);
        vectors++;
        if (entry_st !== 2'd0 || cmd_valid !== 1'b0 || valid_hi - v0 != 1) begin
            miscompares++;
            $display("FAIL seq_issue got st=%0d v=%b valid_cycles=%0d want st=0 v=0 valid_cycles=1",
                     entry_st, cmd_valid, valid_hi - v0);
        end
        vectors++;
        if (cmd_a !== 8'h23 || cmd_b !== 8'h11 || cmd_op !== 4'h1) begin
            miscompares++;
            $display("FAIL seq_retain got a=%h b=%h op=%h want 23 11 1", cmd_a, cmd_b, cmd_op);
        end
    endtask

    task automatic test_backpressure;
        cmd_ready = 1'b0;
        press(8'h5A, 1'b1, 1'b0);
        press(8'hA5, 1'b1, 1'b0);
        exp_q.push_back('{a: 8'h5A, b: 8'hA5, op: 4'h3});
        press(8'h03, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            sw_in     = 8'($urandom);
            btn_enter = ~btn_enter;
            cyc(1);
        end
        press(8'hFF, 1'b1, 1'b0);
        vectors++;
        if (entry_st !== 2'd3 || cmd_valid !== 1'b1 || cmd_a !== 8'h5A || cmd_b !== 8'hA5 || cmd_op !== 4'h3) begin
            miscompares++;
            $display("FAIL bp_hold got st=%0d v=%b a=%h b=%h op=%h want st=3 v=1 a=5a b=a5 op=3",
                     entry_st, cmd_valid, cmd_a, cmd_b, cmd_op);
        end
        cmd_ready = 1'b1;
        wait_handshake("bp");
        cyc(1);
        vectors++;
        if (entry_st !== 2'd0 || cmd_valid !== 1'b0 || cmd_a !== 8'h5A) begin
            miscompares++;
            $display("FAIL bp_release got st=%0d v=%b a=%h want st=0 v=0 a=5a", entry_st, cmd_valid, cmd_a);
        end
    endtask

    task automatic test_glitch;
        int n;
        sw_in = 8'h66;
        btn_enter = 1'b1;
        cyc(2);
        btn_enter = 1'b0;
        cyc(20);
        vectors++;
        if (entry_st !== 2'd0 || cmd_a !== 8'h5A) begin
            miscompares++;
            $display("FAIL glitch_ignored got st=%0d a=%h want st=0 a=5a", entry_st, cmd_a);
        end
        // Pulse appears SS+DB edges after the raw edge; the FSM captures on the next one
        sw_in = 8'h77;
        btn_enter = 1'b1;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (entry_st == 2'd1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != SS + DB + 1 || cmd_a !== 8'h77) begin
            miscompares++;
            $display("FAIL glitch_clean_latency got %0d cycles a=%h want %0d cycles a=77", n, cmd_a, SS + DB + 1);
        end
        #1;
        btn_enter = 1'b0;
        cyc(10);
        press(8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_clear;
        press(8'h40, 1'b1, 1'b0);
        press(8'h41, 1'b1, 1'b0);
        vectors++;
        if (entry_st !== 2'd2) begin
            miscompares++;
            $display("FAIL clr_setup got st=%0d want 2", entry_st);
        end
        press(8'h00, 1'b0, 1'b1);
        vectors++;
        if (entry_st !== 2'd0 || cmd_a !== 8'h40 || cmd_b !== 8'h41) begin
            miscompares++;
            $display("FAIL clr_in_op got st=%0d a=%h b=%h want st=0 a=40 b=41", entry_st, cmd_a, cmd_b);
        end
        cmd_ready = 1'b0;
        press(8'h10, 1'b1, 1'b0);
        press(8'h20, 1'b1, 1'b0);
        exp_q.push_back('{a: 8'h10, b: 8'h20, op: 4'h5});
        press(8'h05, 1'b1, 1'b0);
        press(8'h00, 1'b0, 1'b1);
        vectors++;
        if (entry_st !== 2'd3 || cmd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_in_issue got st=%0d v=%b want st=3 v=1", entry_st, cmd_valid);
        end
        cmd_ready = 1'b1;
        wait_handshake("clr");
        cyc(1);
        press(8'h30, 1'b1, 1'b0);
        press(8'h99, 1'b1, 1'b1);
        vectors++;
        if (entry_st !== 2'd0 || cmd_b !== 8'h20 || cmd_a !== 8'h30) begin
            miscompares++;
            $display("FAIL clr_and_enter got st=%0d a=%h b=%h want st=0 a=30 b=20", entry_st, cmd_a, cmd_b);
        end
    endtask

    task automatic test_reset_mid_handshake;
        cmd_ready = 1'b0;
        press(8'h01, 1'b1, 1'b0);
        press(8'h02, 1'b1, 1'b0);
        press(8'h03, 1'b1, 1'b0);
        vectors++;
        if (cmd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_setup got v=%b want 1", cmd_valid);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if ({cmd_a, cmd_b, cmd_op, cmd_valid, entry_st, timeout} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async got a=%h b=%h op=%h v=%b st=%0d want all 0",
                     cmd_a, cmd_b, cmd_op, cmd_valid, entry_st);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmd_ready = 1'b1;
        cyc(2);
    endtask

    task automatic test_timeout;
        int t0;
        press(8'h55, 1'b1, 1'b0);
        vectors++;
        if (entry_st !== 2'd1) begin
            miscompares++;
            $display("FAIL to_setup got st=%0d want 1", entry_st);
        end
        t0 = to_count;
`ifdef CALC_TIMEOUT_EN
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (entry_st == 2'd0) break;
        end
        cyc(3);
        vectors++;
        if (entry_st !== 2'd0 || to_count - t0 != 1) begin
            miscompares++;
            $display("FAIL to_abort got st=%0d pulses=%0d want st=0 pulses=1", entry_st, to_count - t0);
        end
`else
        cyc(200);
        vectors++;
        if (entry_st !== 2'd1 || to_count != t0) begin
            miscompares++;
            $display("FAIL to_disabled got st=%0d pulses=%0d want st=1 pulses=0", entry_st, to_count - t0);
        end
        press(8'h00, 1'b0, 1'b1);
`endif
    endtask

    initial begin
        test_reset;
        test_enter_sequence;
        test_backpressure;
        test_glitch;
        test_clear;
        test_reset_mid_handshake;
        test_timeout;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
